// File: rtl/stack_engine_if.sv
// Command/response bundle between the control unit (master) and the stack engine (slave).
interface stack_engine_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] wdata;
    logic             rsp_valid;
    logic [WIDTH-1:0] rdata;
    logic             err;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    modport master (
        output op_valid, op, wdata,
        input  op_ready, rsp_valid, rdata, err, count, full, empty
    );

    modport slave (
        input  op_valid, op, wdata,
        output op_ready, rsp_valid, rdata, err, count, full, empty
    );
endinterface

// File: rtl/stack_engine.sv
// Parametrised hardware stack with a fixed-latency IDLE -> BUSY -> RESP access sequence.
// All architectural state (count, rdata, err, storage) commits on the edge entering RESP.
module stack_engine #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LAT   = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    stack_engine_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LAT + 1);

    localparam logic [1:0] OP_PUSH  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] wdata_q;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             op_ready;
    logic             accept;
    logic             commit;
    logic             wr_en;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             is_full;
    logic             is_empty;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign accept   = bus.op_valid & op_ready;
    // With LAT=1 the commit happens on the accept edge itself, so the live inputs are used.
    assign commit   = ((state_q == S_IDLE) && accept && (LAT == 1)) ||
                      ((state_q == S_BUSY) && (lcnt_q == LW'(1)));
    assign cmd_op   = (state_q == S_IDLE) ? bus.op    : op_q;
    assign cmd_data = (state_q == S_IDLE) ? bus.wdata : wdata_q;
    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign wr_idx   = AW'(count_q);
    assign rd_idx   = AW'(count_q - CW'(1));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            lcnt_q  <= '0;
            op_q    <= OP_PUSH;
            wdata_q <= '0;
            count_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                op_q    <= bus.op;
                wdata_q <= bus.wdata;
            end
        end
    end

    // Storage is never cleared; a reset edge simply suppresses the write.
    always_ff @(posedge Clk) begin
        if (Reset && wr_en) begin
            mem_q[wr_idx] <= cmd_data;
        end
    end

    always_comb begin
        state_d = state_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lcnt_d  = LW'(LAT - 1);
                    state_d = (LAT == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                lcnt_d = lcnt_q - LW'(1);
                if (lcnt_q == LW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        if (commit) begin
            case (cmd_op)
                OP_PUSH: begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                        err_d   = 1'b0;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        rdata_d = mem_q[rd_idx];
                        count_d = count_q - CW'(1);
                        err_d   = 1'b0;
                    end
                end
                OP_PEEK: begin
                    if (is_empty) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        rdata_d = mem_q[rd_idx];
                        err_d   = 1'b0;
                    end
                end
                default: begin
                    count_d = '0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    // op_ready is gated by Reset so it is low throughout reset and high as soon as it releases.
    always_comb begin
        op_ready      = (state_q == S_IDLE) && Reset;
        bus.rsp_valid = (state_q == S_RESP);
    end

    assign bus.op_ready = op_ready;
    assign bus.rdata    = rdata_q;
    assign bus.err      = err_q;
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.empty    = is_empty;
endmodule
